// File: rtl/gpio_axil_pkg.sv
// Shared types and constants for the gpio_axil request-to-AXI-Lite bridge.
// Optional watchdog is enabled with the GPIO_AXIL_TIMEOUT_EN macro.
package gpio_axil_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Largest legal timeout; the counter is sized so any legal timeout fits.
  localparam int unsigned TIMEOUT_MAX = 65535;
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/gpio_axil_if.sv
// AXI4-Lite channel bundle between the bridge (master) and the GPIO slave.
interface gpio_axil_if;
  import gpio_axil_pkg::*;

  logic [ADDR_W-1:0] WAddress;
  logic              AWvalid;
  logic              AWready;
  logic [DATA_W-1:0] Wdata;
  logic [STRB_W-1:0] strobe;
  logic              Wvalid;
  logic              Wready;
  logic              Bvalid;
  logic              Bready;
  logic [ADDR_W-1:0] RAddress;
  logic              ARvalid;
  logic              ARready;
  logic              Rvalid;
  logic [DATA_W-1:0] Rdata;
  logic              Rready;

  modport master (
    output WAddress, AWvalid, Wdata, strobe, Wvalid, Bready, RAddress, ARvalid, Rready,
    input  AWready, Wready, Bvalid, ARready, Rvalid, Rdata
  );

  modport slave (
    input  WAddress, AWvalid, Wdata, strobe, Wvalid, Bready, RAddress, ARvalid, Rready,
    output AWready, Wready, Bvalid, ARready, Rvalid, Rdata
  );

endinterface

// File: rtl/gpio_axil_watchdog.sv
// Stall counter: flags expiry on the cycle its count would reach TIMEOUT_CYCLES.
module gpio_axil_watchdog
  import gpio_axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on registered state so it cannot loop back through clear.
  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gpio_axil_master.sv
// Single-outstanding native request to AXI4-Lite master bridge.
// GPIO_AXIL_TIMEOUT_EN adds a watchdog that aborts stalled transactions.
module gpio_axil_master
  import gpio_axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  gpio_axil_if.master       axi
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > TIMEOUT_MAX) begin : g_bad_timeout
    $error("gpio_axil_master: TIMEOUT_CYCLES out of range");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d;
  logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, abort_c;

  assign aw_hs_c = awvalid_q & axi.AWready;
  assign w_hs_c  = wvalid_q  & axi.Wready;
  assign b_hs_c  = bready_q  & axi.Bvalid;
  assign ar_hs_c = arvalid_q & axi.ARready;
  assign r_hs_c  = rready_q  & axi.Rvalid;

  // Next-state and registered-output logic; watchdog abort overrides everything.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    raddr_d     = raddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            waddr_d   = req_addr;
            wdata_d   = req_wdata;
            strb_d    = req_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            raddr_d   = req_addr;
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WRITE: begin
        if (aw_hs_c) awvalid_d = 1'b0;
        if (w_hs_c)  wvalid_d  = 1'b0;
        // Each channel is done once its valid has dropped or drops now.
        if (!(awvalid_q && !aw_hs_c) && !(wvalid_q && !w_hs_c)) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (b_hs_c) begin
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RADDR: begin
        if (ar_hs_c) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (r_hs_c) begin
          rsp_rdata_d = axi.Rdata;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_c) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_rdata_d = '0;
      rsp_valid_d = 1'b1;
      state_d     = RESP;
    end
  end

  // State and output registers; async reset drops every valid/ready at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      raddr_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      raddr_q     <= raddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef GPIO_AXIL_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic any_hs_c, wd_clear_c, wd_enable_c, wd_expired;

  assign any_hs_c    = aw_hs_c | w_hs_c | b_hs_c | ar_hs_c | r_hs_c;
  assign wd_enable_c = (state_q == WRITE) || (state_q == WRESP) ||
                       (state_q == RADDR) || (state_q == RDATA);
  assign wd_clear_c  = (state_d != state_q) || any_hs_c;
  // A handshake on the expiry cycle is progress, so it suppresses the abort.
  assign abort_c     = wd_expired & ~any_hs_c;

  gpio_axil_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear_c),
    .enable (wd_enable_c),
    .expired(wd_expired)
  );

  // Error flag: set by an abort, cleared by the next accepted request.
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (req_valid && req_ready) rsp_err_d = 1'b0;
    if (abort_c)                rsp_err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign abort_c = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign axi.WAddress = waddr_q;
  assign axi.Wdata    = wdata_q;
  assign axi.strobe   = strb_q;
  assign axi.AWvalid  = awvalid_q;
  assign axi.Wvalid   = wvalid_q;
  assign axi.Bready   = bready_q;
  assign axi.RAddress = raddr_q;
  assign axi.ARvalid  = arvalid_q;
  assign axi.Rready   = rready_q;

endmodule

// File: tb/tb_gpio_axil_master.sv
// Directed bench for gpio_axil_master; the timeout scenario runs only
// when GPIO_AXIL_TIMEOUT_EN is defined.
module tb_gpio_axil_master;
  import gpio_axil_pkg::*;

  localparam int unsigned TB_TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  gpio_axil_if axi ();

  gpio_axil_master #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_strb (req_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .axi      (axi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic slave_idle();
    axi.AWready = 1'b0;
    axi.Wready  = 1'b0;
    axi.Bvalid  = 1'b0;
    axi.ARready = 1'b0;
    axi.Rvalid  = 1'b0;
    axi.Rdata   = 32'h0;
  endtask

  // Present a request at the current negedge; it is taken at the next posedge.
  task automatic present(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
  endtask

  // Consume the pending response; returns at the negedge after the handshake.
  task automatic rsp_take();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("idle_rdy", 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1'b0;
    slave_idle();
    #1 reset = 1'b1;
    #1;
    // Reset values
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_awvalid",   32'(axi.AWvalid), 32'd0);
    check("rst_wvalid",    32'(axi.Wvalid), 32'd0);
    check("rst_bready",    32'(axi.Bready), 32'd0);
    check("rst_arvalid",   32'(axi.ARvalid), 32'd0);
    check("rst_rready",    32'(axi.Rready), 32'd0);
    check("rst_waddr",     axi.WAddress, 32'h0);
    check("rst_raddr",     axi.RAddress, 32'h0);
    check("rst_strobe",    32'(axi.strobe), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Write, zero-wait slave
    axi.AWready = 1'b1; axi.Wready = 1'b1; axi.Bvalid = 1'b1;
    present(1'b1, 32'h0000_0EFA, 32'hABCD_EFFF, 4'hF);
    @(negedge clock);
    req_valid = 1'b0;
    check("w1_awvalid", 32'(axi.AWvalid), 32'd1);
    check("w1_wvalid",  32'(axi.Wvalid), 32'd1);
    check("w1_waddr",   axi.WAddress, 32'h0000_0EFA);
    check("w1_wdata",   axi.Wdata, 32'hABCD_EFFF);
    check("w1_strobe",  32'(axi.strobe), 32'hF);
    check("w1_busy",    32'(req_ready), 32'd0);
    check("w1_bready0", 32'(axi.Bready), 32'd0);
    @(negedge clock);
    check("w1_awdrop",  32'(axi.AWvalid), 32'd0);
    check("w1_wdrop",   32'(axi.Wvalid), 32'd0);
    check("w1_bready",  32'(axi.Bready), 32'd1);
    check("w1_norsp",   32'(rsp_valid), 32'd0);
    @(negedge clock);
    check("w1_bdrop",   32'(axi.Bready), 32'd0);
    check("w1_rsp",     32'(rsp_valid), 32'd1);
    check("w1_rdata",   rsp_rdata, 32'h0);
    check("w1_err",     32'(rsp_err), 32'd0);
    slave_idle();
    rsp_take();

    // Write with AWready 2 cycles late, Wready 5 cycles late
    present(1'b1, 32'h0000_EFA6, 32'hABCD_EFF1, 4'h3);
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("w2_awvalid_%0d", k), 32'(axi.AWvalid), (k <= 2) ? 32'd1 : 32'd0);
      check($sformatf("w2_wvalid_%0d", k),  32'(axi.Wvalid), 32'd1);
      check($sformatf("w2_bready_%0d", k),  32'(axi.Bready), 32'd0);
      check($sformatf("w2_waddr_%0d", k),   axi.WAddress, 32'h0000_EFA6);
      axi.AWready = (k == 2);
      axi.Wready  = (k == 5);
      @(negedge clock);
    end
    check("w2_wdrop",  32'(axi.Wvalid), 32'd0);
    check("w2_awdrop", 32'(axi.AWvalid), 32'd0);
    check("w2_bready", 32'(axi.Bready), 32'd1);
    check("w2_strobe", 32'(axi.strobe), 32'h3);
    axi.AWready = 1'b0; axi.Wready = 1'b0; axi.Bvalid = 1'b1;
    @(negedge clock);
    check("w2_rsp",    32'(rsp_valid), 32'd1);
    check("w2_bdrop",  32'(axi.Bready), 32'd0);
    slave_idle();
    rsp_take();

    // Read, data 4 cycles after AR; stray Rvalid before RDATA is ignored
    axi.ARready = 1'b1; axi.Rvalid = 1'b1; axi.Rdata = 32'hDEAD_BEEF;
    present(1'b0, 32'h054C_CB84, 32'h0, 4'h0);
    @(negedge clock);
    req_valid = 1'b0;
    check("r1_arvalid", 32'(axi.ARvalid), 32'd1);
    check("r1_raddr",   axi.RAddress, 32'h054C_CB84);
    check("r1_rready0", 32'(axi.Rready), 32'd0);
    @(negedge clock);
    axi.ARready = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("r1_ardrop_%0d", k), 32'(axi.ARvalid), 32'd0);
      check($sformatf("r1_rready_%0d", k), 32'(axi.Rready), 32'd1);
      check($sformatf("r1_norsp_%0d", k),  32'(rsp_valid), 32'd0);
      axi.Rvalid = (k == 5);
      axi.Rdata  = (k == 5) ? 32'h0000_00AA : 32'hDEAD_BEEF;
      @(negedge clock);
    end
    check("r1_rdrop", 32'(axi.Rready), 32'd0);
    check("r1_rsp",   32'(rsp_valid), 32'd1);
    check("r1_rdata", rsp_rdata, 32'h0000_00AA);
    slave_idle();

    // Response back-pressure for 6 cycles with a new request waiting
    present(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_rsp_%0d", i),     32'(rsp_valid), 32'd1);
      check($sformatf("bp_rdata_%0d", i),   rsp_rdata, 32'h0000_00AA);
      check($sformatf("bp_reqrdy_%0d", i),  32'(req_ready), 32'd0);
      check($sformatf("bp_arvalid_%0d", i), 32'(axi.ARvalid), 32'd0);
      @(negedge clock);
    end
    rsp_take();
    axi.ARready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    check("b2b_arvalid", 32'(axi.ARvalid), 32'd1);
    check("b2b_raddr",   axi.RAddress, 32'h0000_0040);
    axi.Rvalid = 1'b1; axi.Rdata = 32'h1234_5678;
    @(negedge clock);
    check("b2b_rready",  32'(axi.Rready), 32'd1);
    @(negedge clock);
    check("b2b_rsp",     32'(rsp_valid), 32'd1);
    check("b2b_rdata",   rsp_rdata, 32'h1234_5678);
    slave_idle();
    rsp_take();

`ifdef GPIO_AXIL_TIMEOUT_EN
    // Slave never takes AR: abort after TB_TIMEOUT cycles
    present(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("to_arvalid_%0d", k), 32'(axi.ARvalid), 32'd1);
      check($sformatf("to_norsp_%0d", k),   32'(rsp_valid), 32'd0);
      @(negedge clock);
    end
    check("to_ardrop", 32'(axi.ARvalid), 32'd0);
    check("to_rready", 32'(axi.Rready), 32'd0);
    check("to_rsp",    32'(rsp_valid), 32'd1);
    check("to_err",    32'(rsp_err), 32'd1);
    check("to_rdata",  rsp_rdata, 32'h0);
    rsp_take();
    axi.AWready = 1'b1; axi.Wready = 1'b1; axi.Bvalid = 1'b1;
    present(1'b1, 32'h0000_0200, 32'h0000_0077, 4'h1);
    @(negedge clock);
    req_valid = 1'b0;
    check("to_errclr", 32'(rsp_err), 32'd0);
    @(negedge clock);
    @(negedge clock);
    check("to_w_rsp",  32'(rsp_valid), 32'd1);
    slave_idle();
    rsp_take();
`endif

    // Reset asserted mid-WRITE
    present(1'b1, 32'h0000_0010, 32'h0000_0055, 4'h1);
    @(negedge clock);
    req_valid = 1'b0;
    check("rw_awvalid", 32'(axi.AWvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rw_awlow",   32'(axi.AWvalid), 32'd0);
    check("rw_wlow",    32'(axi.Wvalid), 32'd0);
    check("rw_idle",    32'(req_ready), 32'd1);
    check("rw_waddr",   axi.WAddress, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    axi.AWready = 1'b1; axi.Wready = 1'b1; axi.Bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("rw_norsp_%0d", i), 32'(rsp_valid), 32'd0);
      check($sformatf("rw_noaw_%0d", i),  32'(axi.AWvalid), 32'd0);
      check($sformatf("rw_nob_%0d", i),   32'(axi.Bready), 32'd0);
    end
    slave_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
